button_event_arbiter: RTL and testbench

Collects up to N raw push-button inputs and turns them into a single serialized stream of debounced button events. Each event is press, release or long-press and is delivered over a valid/ready handshake. The block owns per-button synchronization, debounce, edge detection and long-press timing, plus a round-robin arbiter that shares one event output among all buttons. It sits between the board button pins and any consumer FSM, such as a menu or mode controller, that wants discrete events instead of levels.

---
 rtl/button_event_arbiter.sv | 173 +++++++++++++++++
 tb/tb_button_event_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: synchronizes, debounces and edge-detects N push buttons,
// times long presses, and serializes press/release/long-press events onto a
// single valid/ready output using a round-robin arbiter.
module button_event_arbiter #(
  parameter int unsigned N_BUTTONS         = 4,
  parameter bit          INVERT            = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned LONG_PRESS_CYCLES = 25000000,
  localparam int unsigned ID_W = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] button_signal,
  output logic                 event_valid,
  input  logic                 event_ready,
  output logic [ID_W-1:0]      event_id,
  output logic [1:0]           event_type,
  output logic [N_BUTTONS-1:0] overflow
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = (LONG_PRESS_CYCLES > 0) ? $clog2(LONG_PRESS_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'b00,
    EV_RELEASE = 2'b01,
    EV_LONG    = 2'b10
  } ev_type_t;

  logic [N_BUTTONS-1:0] sync1, sync2, stable;
  logic [CNT_W-1:0]     cnt [N_BUTTONS];
  logic [N_BUTTONS-1:0] flip, rise, fall, long_hit;
  logic [N_BUTTONS-1:0] pend_press, pend_long, pend_release, any_pend;
  logic [N_BUTTONS-1:0] clr_press, clr_long, clr_release;
  logic [ID_W-1:0]      ptr, win_idx, cand;
  logic                 win_found, load;
  ev_type_t             win_type;
  int unsigned          scan;

  // Two-flop synchronizer followed by a per-button stability counter
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int unsigned i = 0; i < N_BUTTONS; i++) cnt[i] <= '0;
    end else begin
      sync1 <= button_signal ^ {N_BUTTONS{INVERT}};
      sync2 <= sync1;
      for (int unsigned i = 0; i < N_BUTTONS; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (flip[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Debounced level changes this cycle, split into rising and falling edges
  always_comb begin
    flip = '0;
    for (int unsigned i = 0; i < N_BUTTONS; i++)
      flip[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
    rise = flip & sync2;
    fall = flip & ~sync2;
  end

  generate
    if (LONG_PRESS_CYCLES > 0) begin : g_long
      logic [HOLD_W-1:0] hold [N_BUTTONS];

      // Hold timer runs while pressed and saturates at the threshold
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int unsigned i = 0; i < N_BUTTONS; i++) hold[i] <= '0;
        end else begin
          for (int unsigned i = 0; i < N_BUTTONS; i++) begin
            if (!stable[i])
              hold[i] <= '0;
            else if (hold[i] != HOLD_W'(LONG_PRESS_CYCLES))
              hold[i] <= hold[i] + 1'b1;
          end
        end
      end

      // Long-press fires exactly on the edge the timer reaches the threshold
      always_comb begin
        long_hit = '0;
        for (int unsigned i = 0; i < N_BUTTONS; i++)
          long_hit[i] = stable[i] && (hold[i] == HOLD_W'(LONG_PRESS_CYCLES - 1));
      end
    end else begin : g_no_long
      // Long-press disabled
      always_comb long_hit = '0;
    end
  endgenerate

  // Round-robin pick of the first button with pending work, then the
  // per-button type in causal order: press, long, release
  always_comb begin
    any_pend  = pend_press | pend_long | pend_release;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    scan      = 0;
    for (int unsigned i = 0; i < N_BUTTONS; i++) begin
      scan = 32'(ptr) + i;
      if (scan >= N_BUTTONS) scan = scan - N_BUTTONS;
      cand = ID_W'(scan);
      if (!win_found && any_pend[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end

    if (pend_press[win_idx])     win_type = EV_PRESS;
    else if (pend_long[win_idx]) win_type = EV_LONG;
    else                         win_type = EV_RELEASE;

    load        = win_found && (!event_valid || event_ready);
    clr_press   = '0;
    clr_long    = '0;
    clr_release = '0;
    if (load) begin
      case (win_type)
        EV_PRESS: clr_press[win_idx]   = 1'b1;
        EV_LONG:  clr_long[win_idx]    = 1'b1;
        default:  clr_release[win_idx] = 1'b1;
      endcase
    end
  end

  // Pending flags; a new event on an already-pending, ungranted flag is
  // merged and recorded in the sticky overflow bit
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_press   <= '0;
      pend_long    <= '0;
      pend_release <= '0;
      overflow     <= '0;
    end else begin
      pend_press   <= rise | (pend_press & ~clr_press);
      pend_long    <= long_hit | (pend_long & ~clr_long);
      pend_release <= fall | (pend_release & ~clr_release);
      overflow     <= overflow
                    | (rise     & pend_press   & ~clr_press)
                    | (long_hit & pend_long    & ~clr_long)
                    | (fall     & pend_release & ~clr_release);
    end
  end

  // Output slot and round-robin pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      event_valid <= 1'b0;
      event_id    <= '0;
      event_type  <= EV_PRESS;
      ptr         <= '0;
    end else if (load) begin
      event_valid <= 1'b1;
      event_id    <= win_idx;
      event_type  <= win_type;
      ptr         <= (win_idx == ID_W'(N_BUTTONS - 1)) ? '0 : win_idx + 1'b1;
    end else if (event_ready) begin
      event_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter: the stimulus thread pushes the
// expected event (id, type, presentation cycle) and a negedge monitor pops and
// compares on every transfer.
module tb_button_event_arbiter;

  localparam int N = 4;
  localparam int D = 4;
  localparam int L = 20;
  localparam int P = 0;  // press
  localparam int R = 1;  // release
  localparam int G = 2;  // long-press

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] button_signal;
  logic         event_valid;
  logic         event_ready;
  logic [1:0]   event_id;
  logic [1:0]   event_type;
  logic [N-1:0] overflow;

  typedef struct {
    int id;
    int typ;
    int at;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   held   = 1'b0;
  int   held_id, held_type;

  button_event_arbiter #(
    .N_BUTTONS(N),
    .INVERT(1'b1),
    .DEBOUNCE_CYCLES(D),
    .LONG_PRESS_CYCLES(L)
  ) dut (
    .clock(clock),
    .reset(reset),
    .button_signal(button_signal),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_id(event_id),
    .event_type(event_type),
    .overflow(overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic expect_ev(input int id, input int typ, input int at);
    exp_t e;
    e.id  = id;
    e.typ = typ;
    e.at  = at;
    sb.push_back(e);
  endtask

  // Monitor: pop on every transfer, and check the slot stays frozen under backpressure
  always @(negedge clock) begin
    if (event_valid && event_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got id=%0d type=%0d expected none (cycle %0d)",
                 event_id, event_type, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ev_id", int'(event_id), e.id);
        check("ev_type", int'(event_type), e.typ);
        check("ev_cycle", cyc, e.at);
      end
      held = 1'b0;
    end else if (event_valid) begin
      if (held) begin
        check("hold_id", int'(event_id), held_id);
        check("hold_type", int'(event_type), held_type);
      end else begin
        held      = 1'b1;
        held_id   = int'(event_id);
        held_type = int'(event_type);
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    int c;
    button_signal = '1;
    event_ready   = 1'b1;
    reset         = 1'b1;
    tick(3);
    check("rst_valid", int'(event_valid), 0);
    check("rst_id", int'(event_id), 0);
    check("rst_type", int'(event_type), 0);
    check("rst_overflow", int'(overflow), 0);
    reset = 1'b0;
    tick(2);

    // Single press/release on btn0, released before the long threshold
    c = cyc;
    button_signal[0] = 1'b0;
    expect_ev(0, P, c + D + 3);
    wait_until(c + 10);
    button_signal[0] = 1'b1;
    expect_ev(0, R, c + 10 + D + 3);
    wait_until(c + 40);

    // Simultaneous presses under backpressure; ptr is 1 so btn1 wins first
    event_ready = 1'b0;
    c = cyc;
    button_signal[1] = 1'b0;
    button_signal[3] = 1'b0;
    wait_until(c + 17);
    check("bp_valid", int'(event_valid), 1);
    check("bp_id", int'(event_id), 1);
    expect_ev(1, P, c + 17);
    expect_ev(3, P, c + 18);
    event_ready = 1'b1;
    button_signal[1] = 1'b1;
    button_signal[3] = 1'b1;
    expect_ev(1, R, c + 24);
    expect_ev(3, R, c + 25);
    wait_until(c + 40);

    // Bouncing btn1 (2-cycle phases) then held: one press only
    c = cyc;
    for (int p = 0; p < 6; p++) begin
      button_signal[1] = (p % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    button_signal[1] = 1'b0;
    expect_ev(1, P, c + 12 + D + 3);
    wait_until(c + 25);
    button_signal[1] = 1'b1;
    expect_ev(1, R, c + 25 + D + 3);
    wait_until(c + 45);

    // Long press on btn2: long arrives L edges after the stable rise
    c = cyc;
    button_signal[2] = 1'b0;
    expect_ev(2, P, c + D + 3);
    expect_ev(2, G, c + D + 2 + L + 1);
    wait_until(c + 40);
    button_signal[2] = 1'b1;
    expect_ev(2, R, c + 40 + D + 3);
    wait_until(c + 60);

    // Overflow: slot occupied by btn0, btn2 pressed/released twice
    event_ready = 1'b0;
    c = cyc;
    button_signal[0] = 1'b0;
    wait_until(c + 8);
    button_signal[2] = 1'b0;
    wait_until(c + 16);
    button_signal[2] = 1'b1;
    wait_until(c + 24);
    button_signal[2] = 1'b0;
    wait_until(c + 32);
    button_signal[2] = 1'b1;
    wait_until(c + 40);
    check("ovf_bits", int'(overflow), 4);
    check("ovf_slot_id", int'(event_id), 0);
    expect_ev(0, P, c + 40);
    expect_ev(2, P, c + 41);
    expect_ev(0, G, c + 42);
    expect_ev(2, R, c + 43);
    expect_ev(0, R, c + 47);
    event_ready = 1'b1;
    button_signal[0] = 1'b1;
    wait_until(c + 60);

    // Reset mid-handshake with btn0 held and btn0 press pending
    event_ready = 1'b0;
    c = cyc;
    button_signal[0] = 1'b0;
    button_signal[1] = 1'b0;
    wait_until(c + 10);
    check("pre_rst_valid", int'(event_valid), 1);
    check("pre_rst_id", int'(event_id), 1);
    reset = 1'b1;
    button_signal[1] = 1'b1;
    tick(1);
    check("mid_rst_valid", int'(event_valid), 0);
    check("mid_rst_id", int'(event_id), 0);
    check("mid_rst_type", int'(event_type), 0);
    check("mid_rst_overflow", int'(overflow), 0);
    reset = 1'b0;
    event_ready = 1'b1;
    expect_ev(0, P, c + 11 + D + 3);
    wait_until(c + 25);
    button_signal[0] = 1'b1;
    expect_ev(0, R, c + 25 + D + 3);
    wait_until(c + 45);

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
